fifo_demux_router: RTL and testbench

Downstream consumer of the 6-bit FIFO. It pulls words out of the FIFO and steers each one to one of four destination FIFOs, using the two MSBs of the word as the destination ID. It honours per-destination backpressure through a one-word hold register, so no word is ever dropped or duplicated. It reports idle status to the link controller and can optionally count routed words.

---
 rtl/fifo_demux_router.sv | 94 +++++++++
 tb/tb_fifo_demux_router.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_demux_router.sv
// fifo_demux_router: drains the upstream FIFO and steers each word to one of four destinations by its two MSBs.
// Define FIFO_DEMUX_COUNTERS_EN to build the per-destination routed-word counters.
module fifo_demux_router #(
    parameter int DW = 6
`ifdef FIFO_DEMUX_COUNTERS_EN
    , parameter int CW = 8
`endif
) (
    input  logic          clk,
    input  logic          RESET_L,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_data,
    input  logic          fifo_valid,
    output logic          fifo_rd,
    input  logic [3:0]    pause_in,
    output logic [DW-1:0] data_o,
    output logic [3:0]    push_o,
    output logic          idle
`ifdef FIFO_DEMUX_COUNTERS_EN
    , output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1,
    output logic [CW-1:0] cnt2,
    output logic [CW-1:0] cnt3
`endif
);
    typedef enum logic [1:0] {RESET, IDLE, ACTIVE, HOLD} state_t;
    state_t state, nxt;
    logic [DW-1:0] hold;
    logic [1:0] d, held_d;
    logic go, emit, emit_hold, cap;
    logic [3:0] push_n;
    assign d = fifo_data[DW-1 -: 2];
    assign held_d = hold[DW-1 -: 2];
    assign go = !fifo_empty && (pause_in == 4'b0000);
    assign idle = (state == IDLE) && fifo_empty;
    assign push_n = emit ? (4'b0001 << d) : emit_hold ? (4'b0001 << held_d) : 4'b0000;
    always_comb begin
        nxt = state;
        fifo_rd = 1'b0;
        emit = 1'b0;
        emit_hold = 1'b0;
        cap = 1'b0;
        case (state)
            RESET: nxt = IDLE;
            IDLE: begin
                fifo_rd = go;
                if (go) nxt = ACTIVE;
            end
            ACTIVE: begin
                // a word landing on a paused destination parks in the hold register and stops further reads
                if (fifo_valid && pause_in[d]) begin
                    cap = 1'b1;
                    nxt = HOLD;
                end else begin
                    fifo_rd = go;
                    emit = fifo_valid;
                    if (!fifo_valid && !go) nxt = IDLE;
                end
            end
            HOLD: begin
                if (!pause_in[held_d]) begin
                    emit_hold = 1'b1;
                    nxt = IDLE;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!RESET_L) begin
            state <= RESET;
            data_o <= '0;
            push_o <= '0;
            hold <= '0;
`ifdef FIFO_DEMUX_COUNTERS_EN
            cnt0 <= '0;
            cnt1 <= '0;
            cnt2 <= '0;
            cnt3 <= '0;
`endif
        end else begin
            state <= nxt;
            push_o <= push_n;
            if (emit) data_o <= fifo_data;
            else if (emit_hold) data_o <= hold;
            if (cap) hold <= fifo_data;
`ifdef FIFO_DEMUX_COUNTERS_EN
            cnt0 <= cnt0 + CW'(push_n[0]);
            cnt1 <= cnt1 + CW'(push_n[1]);
            cnt2 <= cnt2 + CW'(push_n[2]);
            cnt3 <= cnt3 + CW'(push_n[3]);
`endif
        end
    end
endmodule

// File: tb/tb_fifo_demux_router.sv
// tb_fifo_demux_router: directed stimulus with an upstream FIFO model and a push scoreboard.
module tb_fifo_demux_router;
    logic clk = 1'b0;
    logic RESET_L = 1'b0;
    logic fifo_empty;
    logic [5:0] fifo_data = '0;
    logic fifo_valid = 1'b0;
    logic fifo_rd;
    logic [3:0] pause_in = '0;
    logic [5:0] data_o;
    logic [3:0] push_o;
    logic idle;
`ifdef FIFO_DEMUX_COUNTERS_EN
    logic [7:0] cnt0, cnt1, cnt2, cnt3;
`endif
    int tests = 0;
    int fails = 0;
    logic [5:0] up[$];
    logic [9:0] exp_q[$];

    fifo_demux_router dut (
        .clk(clk), .RESET_L(RESET_L), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_valid(fifo_valid), .fifo_rd(fifo_rd), .pause_in(pause_in), .data_o(data_o),
        .push_o(push_o), .idle(idle)
`ifdef FIFO_DEMUX_COUNTERS_EN
        , .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
`endif
    );

    always #5 clk = ~clk;

    assign fifo_empty = (up.size() == 0);

    // upstream FIFO: a read at edge N presents the word during cycle N+1
    always @(posedge clk) begin
        if (fifo_rd && up.size() != 0) begin
            fifo_data <= up.pop_front();
            fifo_valid <= 1'b1;
        end else begin
            fifo_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (push_o != 4'b0000) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_push got push_o=%b data_o=%b want no push", push_o, data_o);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({push_o, data_o} !== e) begin
                    fails++;
                    $display("FAIL push_word got push_o=%b data_o=%b want push_o=%b data_o=%b",
                             push_o, data_o, e[9:6], e[5:0]);
                end
            end
        end
    end

    task automatic check(input string n, input logic [7:0] a, input logic [7:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s got %0h want %0h", n, a, e);
        end
    endtask

    task automatic send(input logic [5:0] w, input logic [3:0] p);
        up.push_back(w);
        exp_q.push_back({p, w});
    endtask

    task automatic drain(input string n);
        int k;
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && idle) break;
        end
        check({n, "_drain"}, 8'(k < 1000), 8'd1);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_rd", 8'(fifo_rd), 8'd0);
        check("rst_push", 8'(push_o), 8'd0);
        check("rst_data", 8'(data_o), 8'd0);
        check("rst_idle", 8'(idle), 8'd0);
        RESET_L = 1'b1;
        @(negedge clk);
        check("idle_after_rst", 8'(idle), 8'd1);
        send(6'b010010, 4'b0010);
        #1;
        check("single_rd", 8'(fifo_rd), 8'd1);
        @(negedge clk);
        check("single_rd_once", 8'(fifo_rd), 8'd0);
        check("single_no_early_push", 8'(push_o), 8'd0);
        @(negedge clk);
        check("single_push", 8'(push_o), 8'b0010);
        check("single_data", 8'(data_o), 8'b010010);
        drain("single");
        check("single_idle", 8'(idle), 8'd1);

        send(6'b000001, 4'b0001);
        send(6'b110110, 4'b1000);
        send(6'b100100, 4'b0100);
        send(6'b010100, 4'b0010);
        @(negedge clk);
        @(negedge clk);
        check("stream_p0", 8'(push_o), 8'b0001);
        @(negedge clk);
        check("stream_p1", 8'(push_o), 8'b1000);
        @(negedge clk);
        check("stream_p2", 8'(push_o), 8'b0100);
        @(negedge clk);
        check("stream_p3", 8'(push_o), 8'b0010);
        drain("stream");

        send(6'b110000, 4'b1000);
        @(negedge clk);
        pause_in = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_no_push", 8'(push_o), 8'd0);
            check("hold_no_rd", 8'(fifo_rd), 8'd0);
        end
        pause_in = 4'b0000;
        @(negedge clk);
        check("hold_release_push", 8'(push_o), 8'b1000);
        check("hold_release_data", 8'(data_o), 8'b110000);
        drain("hold");

        pause_in = 4'b0100;
        send(6'b001010, 4'b0001);
        send(6'b111111, 4'b1000);
        send(6'b011100, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("gpause_no_rd", 8'(fifo_rd), 8'd0);
            check("gpause_data_kept", 8'(data_o), 8'b110000);
            @(negedge clk);
        end
        pause_in = 4'b0000;
        drain("gpause");

        up.push_back(6'b100111);
        @(negedge clk);
        pause_in = 4'b0100;
        @(negedge clk);
        check("rsthold_no_push", 8'(push_o), 8'd0);
        RESET_L = 1'b0;
        @(negedge clk);
        check("rsthold_rd", 8'(fifo_rd), 8'd0);
        check("rsthold_push", 8'(push_o), 8'd0);
        check("rsthold_data", 8'(data_o), 8'd0);
        check("rsthold_idle", 8'(idle), 8'd0);
        RESET_L = 1'b1;
        pause_in = 4'b0000;
        repeat (4) begin
            @(negedge clk);
            check("rsthold_never_emitted", 8'(push_o), 8'd0);
        end
        check("rsthold_idle_back", 8'(idle), 8'd1);

`ifdef FIFO_DEMUX_COUNTERS_EN
        for (int i = 0; i < 257; i++) send({2'b01, 4'(i)}, 4'b0010);
        drain("cnt");
        check("cnt0", cnt0, 8'd0);
        check("cnt1_wrap", cnt1, 8'd1);
        check("cnt2", cnt2, 8'd0);
        check("cnt3", cnt3, 8'd0);
`endif

        check("scoreboard_empty", 8'(exp_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
